cgr_count_ctrl: RTL and testbench
=================================

Name: cgr_count_ctrl

Overview:
- Sequences one k-mer frequency run over a DNA symbol stream: CLEAR → COUNT → READOUT.
- Owns an enable-gated CGR address generator (x/y shift registers fed by symbol bits) and a simple dual-port count RAM interface.
- For every full k-mer it performs a read-modify-write increment, then streams the table out.
- Sits between the symbol source and the downstream histogram consumer.

Parameters:
- K, 8, k-mer length = shift-register depth per axis.
- CNT_W, 16, count width; counts saturate.
- ADDR_W, 2*K, RAM address width (derived; not overridden independently).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  async active-low reset.
- start  in  1  pulse in IDLE/DONE begins a run; ignored otherwise.
- sym_valid  in  1  symbol valid.
- sym  in  2  symbol {a,b}; a feeds x, b feeds y.
- sym_last  in  1  qualifies the final symbol of the sequence.
- sym_ready  out  1  high only in COUNT.
- ram_raddr  out  ADDR_W  read address.
- ram_re  out  1  read enable; ram_rdata is valid the next cycle.
- ram_rdata  in  CNT_W  read data; RAM is read-first.
- ram_waddr  out  ADDR_W  write address.
- ram_we  out  1  write enable.
- ram_wdata  out  CNT_W  write data.
- out_valid  out  1  readout entry valid.
- out_addr  out  ADDR_W  k-mer address of the entry.
- out_count  out  CNT_W  count of the entry.
- out_ready  in  1  consumer accepts the entry.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; x/y shift registers=0; fill counter=0; pipeline valids=0.
  - All outputs 0.
  - Reset mid-run aborts immediately. RAM contents are then undefined; the next start clears them.
- IDLE/DONE + start → CLEAR. Clear counter=0.
- CLEAR:
  - ram_we=1, ram_wdata=0, ram_waddr=clear counter; one address per cycle.
  - After address 2^ADDR_W-1 → COUNT. Duration exactly 2^ADDR_W cycles.
  - x/y and fill counter are zeroed on entry.
- COUNT:
  - Symbol accepted when sym_valid & sym_ready. On accept: x ← {a, x[K-1:1]}, y ← {b, y[K-1:1]} (newest symbol in MSB). k-mer address = {x_new, y_new}.
  - Fill counter saturates at K. The symbol is counted iff fill (including this symbol) ≥ K, so the first K-1 symbols only prime.
  - Stage R (accept cycle): ram_re=1, ram_raddr=k-mer address.
  - Stage W (next cycle):
    - operand = ram_rdata, unless the previous cycle's write was valid and wrote the same address; then operand = previous ram_wdata (one-deep forward).
    - ram_wdata = operand==2^CNT_W-1 ? operand : operand+1.
    - ram_we=1; ram_waddr = registered stage-R address.
  - Throughput is one symbol/cycle with no stall.
  - On accept with sym_last: sym_ready drops the next cycle; enter DRAIN.
  - If sym_last arrives before K symbols have been accepted, no counts are made.
- DRAIN: one cycle so the last write commits → READOUT with index=0.
- READOUT: two-phase per entry.
  - RD: ram_re=1, ram_raddr=index.
  - OUT: out_valid=1, out_addr=index, out_count=ram_rdata (registered); held stable until out_ready.
  - On handshake: index+1 → RD. After index 2^ADDR_W-1 handshakes → DONE.
- DONE: done=1 until start (→ CLEAR).
- Simultaneous events: start in any busy state is ignored. sym_valid outside COUNT is ignored (not accepted).
- Address arithmetic wraps modulo 2^ADDR_W. Counts never wrap.

Optional Feature:
- CGR_CTRL_SKIP_ZERO_EN defined: in READOUT, entries whose count is 0 produce no out_valid; the controller advances directly to the next RD. DONE is still reached after the last index.
- Undefined: every one of the 2^ADDR_W entries is emitted.

Decomposition:
- Package cgr_pkg: state enum (IDLE, CLEAR, COUNT, DRAIN, READOUT_RD, READOUT_OUT, DONE) and symbol-width constant SYM_W=2.
- Sub-module cgr_addr_gen: the K-deep x/y shift registers.
  - Inputs: shift enable and sync clear.
  - Outputs: {x,y} address and a primed flag.

Test Plan (K=2, CNT_W=16 unless noted):
- Reset mid-COUNT (RST_N low 1 cycle) → all outputs 0, state IDLE. Then start → exactly 16 CLEAR write cycles (ram_wdata=0, addr 0..15).
- Symbols 3,0,2,2(last), one per cycle → writes addr 0x5=1, 0x8=1, 0xC=1. Readout: out_count=1 at addr 5, 8, C; 0 at all other addresses.
- Symbols 2,2,2,2(last) back-to-back → 0xC written 1,2,3 (forward path). Readout: 0xC=3.
- CNT_W=2, symbol 1 ×6 (last on the 6th) → addr 0x3 saturates at 3; never wraps to 0.
- READOUT with out_ready low 5 cycles on entry 0 → out_valid/out_addr/out_count held stable; 16 handshakes total; then done=1.
- CGR_CTRL_SKIP_ZERO_EN with the sequence 3,0,2,2 → exactly 3 out_valid beats (addr 5, 8, C), then DONE.

Source files
------------

// File: rtl/cgr_pkg.sv
// Shared types and constants for the CGR k-mer counting controller.
`timescale 1ns/1ps
package cgr_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    DRAIN,
    READOUT_RD,
    READOUT_OUT,
    DONE
  } state_e;

endpackage

// File: rtl/cgr_addr_gen.sv
// CGR address generator: K-deep x/y shift registers fed by symbol bits {a,b},
// newest symbol in the MSB, with a fill counter that reports a full k-mer.
`timescale 1ns/1ps
module cgr_addr_gen
  import cgr_pkg::*;
#(
  parameter int K = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic [SYM_W-1:0] i_sym,
  output logic [2*K-1:0]   o_addr,
  output logic             o_primed
);

  localparam int FILL_W = $clog2(K + 1);

  logic [K-1:0]      r_x;
  logic [K-1:0]      r_y;
  logic [FILL_W-1:0] r_fill;
  logic [K-1:0]      w_x_new;
  logic [K-1:0]      w_y_new;

  assign w_x_new[K-1] = i_sym[1];
  assign w_y_new[K-1] = i_sym[0];

  for (genvar gi = 0; gi < K - 1; gi++) begin : g_shift
    assign w_x_new[gi] = r_x[gi+1];
    assign w_y_new[gi] = r_y[gi+1];
  end

  // Address and primed flag describe the k-mer including the symbol being shifted in.
  assign o_addr   = {w_x_new, w_y_new};
  assign o_primed = (r_fill >= FILL_W'(K - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_x <= w_x_new;
      r_y <= w_y_new;
      if (r_fill != FILL_W'(K)) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cgr_count_ctrl.sv
// k-mer frequency run controller: CLEAR -> COUNT (read-modify-write increments) -> READOUT.
// Build option: define CGR_CTRL_SKIP_ZERO_EN to suppress zero-count entries during readout.
`timescale 1ns/1ps
module cgr_count_ctrl
  import cgr_pkg::*;
#(
  parameter  int K      = 8,
  parameter  int CNT_W  = 16,
  localparam int ADDR_W = 2 * K
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_sym_valid,
  input  logic [SYM_W-1:0]  i_sym,
  input  logic              i_sym_last,
  output logic              o_sym_ready,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic              o_ram_re,
  input  logic [CNT_W-1:0]  i_ram_rdata,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic              o_ram_we,
  output logic [CNT_W-1:0]  o_ram_wdata,
  output logic              o_out_valid,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [CNT_W-1:0]  o_out_count,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] IDX_MAX = '1;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_w_valid;
  logic [ADDR_W-1:0] r_w_addr;
  logic              r_fw_valid;
  logic [ADDR_W-1:0] r_fw_addr;
  logic [CNT_W-1:0]  r_fw_data;
  logic              r_rd_pend;
  logic [CNT_W-1:0]  r_out_count;

  logic              w_accept;
  logic [ADDR_W-1:0] w_kmer_addr;
  logic              w_primed;
  logic [CNT_W-1:0]  w_operand;
  logic [CNT_W-1:0]  w_inc;
  logic [CNT_W-1:0]  w_cur_count;
  logic              w_skip;
  logic              w_advance;
  logic              w_idx_last;

  cgr_addr_gen #(
    .K(K)
  ) u_addr_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (r_state == CLEAR),
    .i_shift (w_accept),
    .i_sym   (i_sym),
    .o_addr  (w_kmer_addr),
    .o_primed(w_primed)
  );

  assign w_accept   = (r_state == COUNT) && i_sym_valid;
  assign w_idx_last = (r_idx == IDX_MAX);

  // The RAM cannot yet show the write issued last cycle, so take that value directly.
  assign w_operand = (r_fw_valid && (r_fw_addr == r_w_addr)) ? r_fw_data : i_ram_rdata;
  assign w_inc     = (w_operand == CNT_MAX) ? w_operand : w_operand + CNT_W'(1);

  // Read data lands in the first OUT cycle; afterwards the captured copy holds the entry.
  assign w_cur_count = r_rd_pend ? i_ram_rdata : r_out_count;

`ifdef CGR_CTRL_SKIP_ZERO_EN
  assign w_skip = (r_state == READOUT_OUT) && (w_cur_count == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_advance = (r_state == READOUT_OUT) && (w_skip || i_out_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE:  if (i_start) w_state_next = CLEAR;
      CLEAR:       if (w_idx_last) w_state_next = COUNT;
      COUNT:       if (w_accept && i_sym_last) w_state_next = DRAIN;
      DRAIN:       w_state_next = READOUT_RD;
      READOUT_RD:  w_state_next = READOUT_OUT;
      READOUT_OUT: if (w_advance) w_state_next = w_idx_last ? DONE : READOUT_RD;
      default:     w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_sym_ready = (r_state == COUNT);
    o_busy      = (r_state != IDLE) && (r_state != DONE);
    o_done      = (r_state == DONE);
    o_ram_re    = 1'b0;
    o_ram_raddr = '0;
    o_ram_we    = 1'b0;
    o_ram_waddr = '0;
    o_ram_wdata = '0;
    o_out_valid = 1'b0;
    o_out_addr  = '0;
    o_out_count = '0;
    unique case (r_state)
      CLEAR: begin
        o_ram_we    = 1'b1;
        o_ram_waddr = r_idx;
      end
      COUNT: begin
        o_ram_re    = w_accept && w_primed;
        o_ram_raddr = w_kmer_addr;
      end
      READOUT_RD: begin
        o_ram_re    = 1'b1;
        o_ram_raddr = r_idx;
      end
      READOUT_OUT: begin
        o_out_valid = !w_skip;
        o_out_addr  = r_idx;
        o_out_count = w_cur_count;
      end
      default: ;
    endcase
    // Increment write-back: in COUNT, or in DRAIN for the final symbol.
    if (r_w_valid) begin
      o_ram_we    = 1'b1;
      o_ram_waddr = r_w_addr;
      o_ram_wdata = w_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_w_valid   <= 1'b0;
      r_w_addr    <= '0;
      r_fw_valid  <= 1'b0;
      r_fw_addr   <= '0;
      r_fw_data   <= '0;
      r_rd_pend   <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_w_valid  <= w_accept && w_primed;
      r_w_addr   <= w_kmer_addr;
      r_fw_valid <= r_w_valid;
      r_fw_addr  <= r_w_addr;
      r_fw_data  <= w_inc;
      r_rd_pend  <= (r_state == READOUT_RD);
      if (r_rd_pend) begin
        r_out_count <= i_ram_rdata;
      end
      unique case (r_state)
        IDLE, DONE:  if (i_start) r_idx <= '0;
        CLEAR:       r_idx <= r_idx + 1'b1;
        DRAIN:       r_idx <= '0;
        READOUT_OUT: if (w_advance) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cgr_count_ctrl.sv
// Bench for cgr_count_ctrl: two instances (CNT_W=16 and CNT_W=2, K=2) share stimulus;
// a histogram model predicts every increment write and every readout entry.
`timescale 1ns/1ps
module tb_cgr_count_ctrl;

  localparam int K  = 2;
  localparam int AW = 2 * K;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n, start, sym_valid, sym_last, out_ready;
  logic [1:0] sym;

  logic          a_sym_ready, a_re, a_we, a_out_valid, a_busy, a_done;
  logic [AW-1:0] a_raddr, a_waddr, a_out_addr;
  logic [15:0]   a_rdata, a_wdata, a_out_count;
  logic          b_sym_ready, b_re, b_we, b_out_valid, b_busy, b_done;
  logic [AW-1:0] b_raddr, b_waddr, b_out_addr;
  logic [1:0]    b_rdata, b_wdata, b_out_count;

  logic [15:0] a_mem [N];
  logic [1:0]  b_mem [N];

  always #5 clk = ~clk;

  cgr_count_ctrl #(.K(K), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sym_valid(sym_valid), .i_sym(sym),
    .i_sym_last(sym_last), .o_sym_ready(a_sym_ready), .o_ram_raddr(a_raddr), .o_ram_re(a_re),
    .i_ram_rdata(a_rdata), .o_ram_waddr(a_waddr), .o_ram_we(a_we), .o_ram_wdata(a_wdata),
    .o_out_valid(a_out_valid), .o_out_addr(a_out_addr), .o_out_count(a_out_count),
    .i_out_ready(out_ready), .o_busy(a_busy), .o_done(a_done)
  );

  cgr_count_ctrl #(.K(K), .CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sym_valid(sym_valid), .i_sym(sym),
    .i_sym_last(sym_last), .o_sym_ready(b_sym_ready), .o_ram_raddr(b_raddr), .o_ram_re(b_re),
    .i_ram_rdata(b_rdata), .o_ram_waddr(b_waddr), .o_ram_we(b_we), .o_ram_wdata(b_wdata),
    .o_out_valid(b_out_valid), .o_out_addr(b_out_addr), .o_out_count(b_out_count),
    .i_out_ready(out_ready), .o_busy(b_busy), .o_done(b_done)
  );

  // Read-first simple dual-port RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (a_we) a_mem[a_waddr] <= a_wdata;
    if (a_re) a_rdata <= a_mem[a_raddr];
    if (b_we) b_mem[b_waddr] <= b_wdata;
    if (b_re) b_rdata <= b_mem[b_raddr];
  end

  typedef struct {
    int addr;
    int v16;
    int v2;
  } wr_t;

  int  hist16 [N];
  int  hist2  [N];
  int  cap16  [N];
  int  cap2   [N];
  int  win[$];
  int  seq[$];
  wr_t wq[$];
  int  nacc, exp_idx, entries;
  bit  cnt_phase, tb_end, use_last;
  int  n_assert, n_fail;
  bit  p_valid, p_ready;
  int  p_addr, p_c16, p_c2;
  wr_t m_e;
  int  m_ea;
  bit  ok;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // k-mer address from the last K symbols: newest symbol's bits in the MSB of each axis.
  function automatic void model_sym(input int s);
    int x, y, v, addr;
    nacc++;
    win.push_back(s);
    if (win.size() > K) void'(win.pop_front());
    if (nacc >= K) begin
      x = 0;
      y = 0;
      for (int i = 0; i < K; i++) begin
        v = win[K-1-i];
        x |= ((v >> 1) & 1) << (K - 1 - i);
        y |= (v & 1) << (K - 1 - i);
      end
      addr = (x << K) | y;
      hist16[addr] = (hist16[addr] >= 65535) ? 65535 : hist16[addr] + 1;
      hist2[addr]  = (hist2[addr] >= 3) ? 3 : hist2[addr] + 1;
      wq.push_back('{addr, hist16[addr], hist2[addr]});
    end
  endfunction

  function automatic int next_exp(input int from);
    int f;
    f = from;
`ifdef CGR_CTRL_SKIP_ZERO_EN
    while (f < N && hist16[f] == 0) f++;
`endif
    return f;
  endfunction

  function automatic int exp_entries();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
`ifdef CGR_CTRL_SKIP_ZERO_EN
      if (hist16[i] != 0) c++;
`else
      c++;
`endif
    end
    return c;
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_a"}, {a_sym_ready, a_raddr, a_re, a_waddr, a_we, a_wdata, a_out_valid,
                       a_out_addr, a_out_count, a_busy, a_done}, 0);
    chk({name, "_b"}, {b_sym_ready, b_raddr, b_re, b_waddr, b_we, b_wdata, b_out_valid,
                       b_out_addr, b_out_count, b_busy, b_done}, 0);
  endtask

  task automatic start_clear();
    for (int i = 0; i < N; i++) begin
      hist16[i] = 0;
      hist2[i]  = 0;
      cap16[i]  = 0;
      cap2[i]   = 0;
    end
    win.delete();
    wq.delete();
    nacc      = 0;
    exp_idx   = 0;
    entries   = 0;
    cnt_phase = 0;
    @(posedge clk); #1;
    start     = 1;
    sym_valid = 1;
    sym       = 2'(seq[0]);
    sym_last  = use_last && (seq.size() == 1);
    @(posedge clk); #1;
    start = 0;
    // Symbols are offered throughout CLEAR and must not be accepted there.
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("clr_we", a_we, 1);
      chk("clr_addr", a_waddr, i);
      chk("clr_data", a_wdata, 0);
      chk("clr_ready", a_sym_ready, 0);
    end
    cnt_phase = 1;
  endtask

  task automatic feed();
    for (int j = 0; j < seq.size(); j++) begin
      sym       = 2'(seq[j]);
      sym_last  = use_last && (j == seq.size() - 1);
      sym_valid = 1;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge clk);
        ok = a_sym_ready;
      end
      chk("sym_ready_timeout", ok, 1);
      model_sym(seq[j]);
      @(posedge clk); #1;
    end
    sym_valid = 0;
    sym_last  = 0;
  endtask

  task automatic finish_run(input string name);
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = a_done;
    end
    chk({name, "_done_timeout"}, ok, 1);
    chk({name, "_done_b"}, b_done, 1);
    chk({name, "_busy"}, a_busy, 0);
    chk({name, "_entries"}, entries, exp_entries());
    chk({name, "_writes_left"}, wq.size(), 0);
    $display("run %s: %0d readout entries, done=%0d", name, entries, a_done);
  endtask

  initial begin
    rst_n = 0; start = 0; sym_valid = 0; sym_last = 0; sym = 0; out_ready = 1;
    n_assert = 0; n_fail = 0; tb_end = 0; cnt_phase = 0; p_valid = 0;
    fork
      begin : stim
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        // Abort a run mid-COUNT with a one-cycle reset.
        seq = '{3, 0}; use_last = 0;
        start_clear();
        feed();
        @(negedge clk);
        chk("busy_mid_count", a_busy, 1);
        @(posedge clk); #1;
        rst_n = 0; cnt_phase = 0; wq.delete();
        @(negedge clk);
        chk_all_zero("mid_reset");
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk_all_zero("after_abort");
        $display("abort: reset mid-COUNT returned to idle");

        // One symbol per cycle, plus a start pulse while busy that must be ignored.
        seq = '{3, 0, 2, 2}; use_last = 1;
        start_clear();
        feed();
        @(negedge clk);
        chk("ready_drop", a_sym_ready, 0);
        chk("busy_drain", a_busy, 1);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        finish_run("basic");
        chk("lit_basic_5", cap16[5], 1);
        chk("lit_basic_8", cap16[8], 1);
        chk("lit_basic_c", cap16[12], 1);
        chk("lit_basic_0", cap16[0], 0);

        // Same k-mer back to back exercises the forwarding path.
        seq = '{2, 2, 2, 2};
        start_clear();
        feed();
        finish_run("forward");
        chk("lit_fwd_c16", cap16[12], 3);
        chk("lit_fwd_c2", cap2[12], 3);

        // Saturation on the 2-bit counter.
        seq = '{1, 1, 1, 1, 1, 1};
        start_clear();
        feed();
        finish_run("saturate");
        chk("lit_sat_16", cap16[3], 5);
        chk("lit_sat_2", cap2[3], 3);

        // Consumer backpressure on the first emitted entry.
        seq = '{3, 0, 2, 2};
        out_ready = 0;
        start_clear();
        feed();
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
          @(negedge clk);
          ok = a_out_valid;
        end
        chk("stall_valid_timeout", ok, 1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_valid", a_out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1;
        finish_run("stall");

        // sym_last before a full k-mer: nothing is counted.
        seq = '{2};
        start_clear();
        feed();
        finish_run("short");
        chk("lit_short_c", cap16[12], 0);

        tb_end = 1;
      end
      begin : monitor
        while (!tb_end) begin
          @(negedge clk);
          if (rst_n) begin
            if (cnt_phase && (a_we || b_we)) begin
              chk("we_pair", b_we, a_we);
              if (wq.size() == 0) begin
                chk("unexpected_write", 1, 0);
              end else begin
                m_e = wq.pop_front();
                chk("waddr16", a_waddr, m_e.addr);
                chk("wdata16", a_wdata, m_e.v16);
                chk("waddr2", b_waddr, m_e.addr);
                chk("wdata2", b_wdata, m_e.v2);
                $display("write addr=%0h cnt16=%0d cnt2=%0d", a_waddr, a_wdata, b_wdata);
              end
            end
            if (p_valid && !p_ready) begin
              chk("hold_valid", a_out_valid, 1);
              chk("hold_addr", a_out_addr, p_addr);
              chk("hold_cnt16", a_out_count, p_c16);
              chk("hold_cnt2", b_out_count, p_c2);
            end
            if (a_out_valid) begin
              chk("valid_pair", b_out_valid, 1);
              if (out_ready) begin
                m_ea = next_exp(exp_idx);
                chk("out_addr16", a_out_addr, m_ea);
                chk("out_addr2", b_out_addr, m_ea);
                chk("out_cnt16", a_out_count, (m_ea < N) ? hist16[m_ea] : -1);
                chk("out_cnt2", b_out_count, (m_ea < N) ? hist2[m_ea] : -1);
                cap16[a_out_addr] = int'(a_out_count);
                cap2[a_out_addr]  = int'(b_out_count);
                exp_idx = m_ea + 1;
                entries++;
                $display("readout addr=%0h cnt16=%0d cnt2=%0d", a_out_addr, a_out_count, b_out_count);
              end
            end
            p_valid = a_out_valid;
            p_ready = out_ready;
            p_addr  = int'(a_out_addr);
            p_c16   = int'(a_out_count);
            p_c2    = int'(b_out_count);
          end else begin
            p_valid = 0;
          end
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
